// File: rtl/ec_engine_arbiter.sv
// Round-robin arbiter that shares one EC point engine between NUM_REQ requesters.
// Optional WAIT-state watchdog is enabled by defining EC_ARB_TIMEOUT_EN.
module ec_engine_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned W           = 6,
  parameter int unsigned IDW         = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*6*W-1:0] req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [W-1:0]           rsp_Rx,
  output logic [W-1:0]           rsp_Ry,
  output logic                   rsp_err,
  output logic                   eng_in_valid,
  output logic [W-1:0]           eng_Px,
  output logic [W-1:0]           eng_Py,
  output logic [W-1:0]           eng_Qx,
  output logic [W-1:0]           eng_Qy,
  output logic [W-1:0]           eng_prime,
  output logic [W-1:0]           eng_a,
  input  logic                   eng_out_valid,
  input  logic [W-1:0]           eng_Rx,
  input  logic [W-1:0]           eng_Ry
);

  localparam int unsigned OpW = 6 * W;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [OpW-1:0] op_q, op_d;
  logic [W-1:0]   rx_q, rx_d;
  logic [W-1:0]   ry_q, ry_d;

`ifdef EC_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    int unsigned idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
`ifdef EC_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          gnt_d   = gnt_idx;
          op_d    = req_op[32'(gnt_idx) * OpW +: OpW];
          state_d = StIssue;
        end
      end
      StIssue: begin
`ifdef EC_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (eng_out_valid) begin
          rx_d    = eng_Rx;
          ry_d    = eng_Ry;
`ifdef EC_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = StResp;
        end
`ifdef EC_ARB_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          // Last of TIMEOUT_CYC wait cycles with no result: report a watchdog error.
          rx_d    = '0;
          ry_d    = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      StResp: begin
        if (rsp_ready) begin
          rr_ptr_d = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + IDW'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      op_q     <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
`ifdef EC_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
`ifdef EC_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Outputs are gated by state (and rst) so every idle/unused output reads 0.
  always_comb begin
    req_ready    = '0;
    if (!rst && state_q == StIdle && gnt_any) begin
      req_ready = NUM_REQ'(1) << gnt_idx;
    end
    eng_in_valid = !rst && (state_q == StIssue);
    {eng_Px, eng_Py, eng_Qx, eng_Qy, eng_prime, eng_a} = eng_in_valid ? op_q : '0;
    rsp_valid    = !rst && (state_q == StResp);
    rsp_id       = rsp_valid ? gnt_q : '0;
    rsp_Rx       = rsp_valid ? rx_q : '0;
    rsp_Ry       = rsp_valid ? ry_q : '0;
`ifdef EC_ARB_TIMEOUT_EN
    rsp_err      = rsp_valid & err_q;
`else
    rsp_err      = 1'b0;
`endif
  end

endmodule
